// File: rtl/uart_tx_sched.sv
// uart_tx_sched: sequences the UART transmitter for two result producers,
// register-file read data (1 byte) and ALU results (2 bytes, LSB first).
// Latency: accept at edge N with the scheduler idle -> start strobe from edge N+1 to N+2.
// Backpressure: one pending slot per source (READY = slot empty); no strobe while TX_BUSY=1.
//
// Ports:
//   CLK, RST             clock (rising edge), asynchronous active-low reset
//   RD_DATA/VALID/READY  register read byte, accepted on RD_VALID & RD_READY
//   ALU_OUT/VALID/READY  ALU result, accepted on ALU_VALID & ALU_READY
//   TX_P_DATA            byte presented to the UART TX, held until the next load
//   TX_DATA_VALID        one-cycle start strobe to the UART TX
//   TX_BUSY              Busy from the UART TX FSM (already synchronized)
//   GRANT                one-hot owner: bit0 = RD, bit1 = ALU, 00 when idle
//   SCHED_BUSY           high whenever the scheduler is not idle
//
// Optional feature: define TX_SCHED_RR_EN for round-robin arbitration between the
// two sources; otherwise ALU has fixed priority over RD.
module uart_tx_sched #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RD_DATA,
  input  logic                    RD_VALID,
  output logic                    RD_READY,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_VALID,
  output logic                    ALU_READY,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_DATA_VALID,
  input  logic                    TX_BUSY,
  output logic [1:0]              GRANT,
  output logic                    SCHED_BUSY
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

  state_t                  state, state_nxt;
  logic                    rd_pend, alu_pend;
  logic [DATA_WIDTH-1:0]   rd_slot;
  logic [2*DATA_WIDTH-1:0] alu_slot;
  logic                    byte_idx, byte_idx_nxt;
  logic [DATA_WIDTH-1:0]   tx_dat_nxt;
  logic [1:0]              grant_nxt;
  logic                    rd_clr, alu_clr;
  logic                    pick_alu;

`ifdef TX_SCHED_RR_EN
  // 1 = ALU owned the most recently completed transaction; reset value is RD.
  logic last_alu, last_alu_nxt;

  // On contention the source that did not finish last gets the datapath.
  assign pick_alu = alu_pend && (!rd_pend || !last_alu);
`else
  assign pick_alu = alu_pend;
`endif

  assign RD_READY  = !rd_pend;
  assign ALU_READY = !alu_pend;

  always_comb begin
    state_nxt    = state;
    byte_idx_nxt = byte_idx;
    tx_dat_nxt   = TX_P_DATA;
    grant_nxt    = GRANT;
    rd_clr       = 1'b0;
    alu_clr      = 1'b0;
`ifdef TX_SCHED_RR_EN
    last_alu_nxt = last_alu;
`endif
    case (state)
      IDLE: begin
        if (rd_pend || alu_pend) begin
          state_nxt    = SEND;
          byte_idx_nxt = 1'b0;
          if (pick_alu) begin
            grant_nxt  = 2'b10;
            tx_dat_nxt = alu_slot[DATA_WIDTH-1:0];
          end else begin
            grant_nxt  = 2'b01;
            tx_dat_nxt = rd_slot;
          end
        end
      end
      SEND: state_nxt = WAIT_HI;
      WAIT_HI: begin
        if (TX_BUSY) state_nxt = WAIT_LO;
      end
      WAIT_LO: begin
        if (!TX_BUSY) begin
          if (GRANT[1] && !byte_idx) begin
            // ALU upper byte goes straight out; the owner stays locked.
            tx_dat_nxt   = alu_slot[2*DATA_WIDTH-1:DATA_WIDTH];
            byte_idx_nxt = 1'b1;
            state_nxt    = SEND;
          end else begin
            rd_clr    = GRANT[0];
            alu_clr   = GRANT[1];
            grant_nxt = 2'b00;
            state_nxt = IDLE;
`ifdef TX_SCHED_RR_EN
            last_alu_nxt = GRANT[1];
`endif
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state         <= IDLE;
      byte_idx      <= 1'b0;
      TX_P_DATA     <= '0;
      TX_DATA_VALID <= 1'b0;
      GRANT         <= 2'b00;
      SCHED_BUSY    <= 1'b0;
`ifdef TX_SCHED_RR_EN
      last_alu      <= 1'b0;
`endif
    end else begin
      state         <= state_nxt;
      byte_idx      <= byte_idx_nxt;
      TX_P_DATA     <= tx_dat_nxt;
      // Strobe and busy flag follow the next state so they line up with SEND/non-IDLE.
      TX_DATA_VALID <= (state_nxt == SEND);
      GRANT         <= grant_nxt;
      SCHED_BUSY    <= (state_nxt != IDLE);
`ifdef TX_SCHED_RR_EN
      last_alu      <= last_alu_nxt;
`endif
    end
  end

  // Clear only ever hits a pending slot, so it never collides with an accept.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_pend  <= 1'b0;
      rd_slot  <= '0;
      alu_pend <= 1'b0;
      alu_slot <= '0;
    end else begin
      if (rd_clr) begin
        rd_pend <= 1'b0;
      end else if (RD_VALID && !rd_pend) begin
        rd_pend <= 1'b1;
        rd_slot <= RD_DATA;
      end
      if (alu_clr) begin
        alu_pend <= 1'b0;
      end else if (ALU_VALID && !alu_pend) begin
        alu_pend <= 1'b1;
        alu_slot <= ALU_OUT;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
`timescale 1ns/1ps
module tb_uart_tx_sched;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RD_DATA;
  logic        RD_VALID;
  logic        RD_READY;
  logic [15:0] ALU_OUT;
  logic        ALU_VALID;
  logic        ALU_READY;
  logic [7:0]  TX_P_DATA;
  logic        TX_DATA_VALID;
  logic        TX_BUSY;
  logic [1:0]  GRANT;
  logic        SCHED_BUSY;

  uart_tx_sched #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST),
    .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .RD_READY(RD_READY),
    .ALU_OUT(ALU_OUT), .ALU_VALID(ALU_VALID), .ALU_READY(ALU_READY),
    .TX_P_DATA(TX_P_DATA), .TX_DATA_VALID(TX_DATA_VALID), .TX_BUSY(TX_BUSY),
    .GRANT(GRANT), .SCHED_BUSY(SCHED_BUSY)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // TX side: Busy is the OR of a directed driver and an automatic UART model.
  logic busy_man  = 1'b0;
  logic busy_auto = 1'b0;
  assign TX_BUSY = busy_man | busy_auto;
  bit tx_auto  = 1'b0;
  int tx_delay = 0;
  int tx_len   = 1;

  logic [7:0] cap_q[$];   // every strobed byte, in order
  logic [7:0] exp_q[$];   // reference byte order for the current scenario
  int         base = 0;   // cap_q index where the current scenario starts

`ifdef TX_SCHED_RR_EN
  bit m_last_alu = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  // Strobe monitor: records bytes and checks no strobe overlaps Busy.
  always @(negedge CLK) begin
    if (RST === 1'b1 && TX_DATA_VALID === 1'b1) begin
      cap_q.push_back(TX_P_DATA);
      check("strobe_while_busy", {31'b0, TX_BUSY}, 32'd0);
    end
  end

  // Automatic UART TX model: Busy rises tx_delay+1 cycles after a strobe, lasts tx_len cycles.
  initial forever begin
    @(negedge CLK);
    if (tx_auto && RST === 1'b1 && TX_DATA_VALID === 1'b1) begin
      repeat (tx_delay) @(posedge CLK);
      @(posedge CLK);
      #1;
      busy_auto = 1'b1;
      repeat (tx_len) begin
        @(posedge CLK);
        #1;
      end
      busy_auto = 1'b0;
    end
  end

  task automatic inject(input bit do_rd, input logic [7:0] rd_d,
                        input bit do_alu, input logic [15:0] alu_d);
    RD_VALID  = do_rd;
    RD_DATA   = rd_d;
    ALU_VALID = do_alu;
    ALU_OUT   = alu_d;
    cyc();
    RD_VALID  = 1'b0;
    ALU_VALID = 1'b0;
  endtask

  // Reference: one transaction contributes its bytes in wire order.
  task automatic expect_txn(input bit alu, input logic [7:0] rd_d, input logic [15:0] alu_d);
    if (alu) begin
      exp_q.push_back(alu_d[7:0]);
      exp_q.push_back(alu_d[15:8]);
    end else begin
      exp_q.push_back(rd_d);
    end
`ifdef TX_SCHED_RR_EN
    m_last_alu = alu;
`endif
  endtask

  // Both sources pending in the same idle cycle: which one goes first.
  function automatic bit first_is_alu();
`ifdef TX_SCHED_RR_EN
    return !m_last_alu;
`else
    return 1'b1;
`endif
  endfunction

  task automatic wait_idle(input string tag, input int max_cyc);
    int n = 0;
    smp();
    while (!(RD_READY === 1'b1 && ALU_READY === 1'b1 && SCHED_BUSY === 1'b0) && n < max_cyc) begin
      smp();
      n++;
    end
    check({tag, "_idle_timeout"}, {31'b0, (n < max_cyc)}, 32'd1);
  endtask

  task automatic compare_bytes(input string tag);
    check({tag, "_count"}, cap_q.size() - base, exp_q.size());
    foreach (exp_q[i]) begin
      if (base + i < cap_q.size())
        check({tag, "_byte"}, cap_q[base + i], exp_q[i]);
    end
    exp_q.delete();
    base = cap_q.size();
  endtask

  task automatic check_rst(input string tag);
    check({tag, "_tx_dat"}, TX_P_DATA, 0);
    check({tag, "_tx_vld"}, TX_DATA_VALID, 0);
    check({tag, "_grant"}, GRANT, 0);
    check({tag, "_sched_busy"}, SCHED_BUSY, 0);
    check({tag, "_rd_ready"}, RD_READY, 1);
    check({tag, "_alu_ready"}, ALU_READY, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  d;
    logic [15:0] a;
    bit          fa;
    int          kind, k;

    RST = 1'b0; RD_DATA = '0; RD_VALID = 1'b0; ALU_OUT = '0; ALU_VALID = 1'b0;
    #2;
    check_rst("por");
    cyc(2);
    RST = 1'b1;

    // RD only, cycle-exact: accept at edge 0, strobe during cycle 1 only.
    smp();
    inject(1'b1, 8'hA5, 1'b0, 16'h0);
    smp();
    check("rd_ready_after_acc", RD_READY, 0);
    check("no_strobe_cycle0", TX_DATA_VALID, 0);
    cyc(); smp();
    check("rd_strobe", TX_DATA_VALID, 1);
    check("rd_data", TX_P_DATA, 8'hA5);
    check("rd_grant", GRANT, 2'b01);
    check("rd_sched_busy", SCHED_BUSY, 1);
    cyc(); smp();
    check("rd_strobe_one_cycle", TX_DATA_VALID, 0);
    busy_man = 1'b1;
    cyc(11);
    busy_man = 1'b0;
    smp();
    check("rd_grant_held", GRANT, 2'b01);
    check("rd_ready_held", RD_READY, 0);
    cyc(); smp();
    check("rd_grant_released", GRANT, 0);
    check("rd_ready_back", RD_READY, 1);
    check("rd_sched_idle", SCHED_BUSY, 0);
    expect_txn(1'b0, 8'hA5, 16'h0);
    compare_bytes("rd_only");

    // ALU two-byte, LSB first.
    tx_auto = 1'b1; tx_delay = 1; tx_len = 11;
    inject(1'b0, 8'h0, 1'b1, 16'h1234);
    expect_txn(1'b1, 8'h0, 16'h1234);
    wait_idle("alu", 300);
    compare_bytes("alu_two_byte");

    // Contention: both accepted in the same cycle.
    inject(1'b1, 8'h11, 1'b1, 16'hBEEF);
    fa = first_is_alu();
    expect_txn(fa, 8'h11, 16'hBEEF);
    expect_txn(!fa, 8'h11, 16'hBEEF);
    wait_idle("contention", 300);
    compare_bytes("contention");

    // Backpressure: Busy held for 40 cycles; a new RD_VALID against a full slot is ignored.
    tx_auto = 1'b0;
    inject(1'b1, 8'h5A, 1'b0, 16'h0);
    cyc(2);
    busy_man = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i >= 5 && i < 20) begin
        RD_VALID = 1'b1;
        RD_DATA  = 8'h77;
      end else begin
        RD_VALID = 1'b0;
      end
      cyc();
    end
    smp();
    check("bp_one_strobe", cap_q.size() - base, 1);
    check("bp_data_stable", TX_P_DATA, 8'h5A);
    check("bp_rd_ready", RD_READY, 0);
    check("bp_grant", GRANT, 2'b01);
    busy_man = 1'b0;
    expect_txn(1'b0, 8'h5A, 16'h0);
    wait_idle("bp", 50);
    cyc(10);
    compare_bytes("backpressure");

    // Reset in WAIT_LO of ALU byte 0: the upper byte must never appear.
    smp();
    inject(1'b0, 8'h0, 1'b1, 16'h1234);
    cyc();
    cyc();
    busy_man = 1'b1;
    cyc(2);
    RST = 1'b0;
    #1;
    check_rst("midrst");
    busy_man = 1'b0;
    cyc(2);
    RST = 1'b1;
`ifdef TX_SCHED_RR_EN
    m_last_alu = 1'b0;
`endif
    exp_q.push_back(8'h34);
    cyc(30);
    smp();
    check_rst("post_rst_idle");
    compare_bytes("mid_reset");

    // Busy never rises: scheduler parks in WAIT_HI until it does.
    d = 8'($urandom);
    inject(1'b1, d, 1'b0, 16'h0);
    cyc(30);
    smp();
    check("stall_sched_busy", SCHED_BUSY, 1);
    check("stall_grant", GRANT, 2'b01);
    check("stall_no_strobe", TX_DATA_VALID, 0);
    check("stall_one_strobe", cap_q.size() - base, 1);
    busy_man = 1'b1;
    cyc(3);
    busy_man = 1'b0;
    expect_txn(1'b0, d, 16'h0);
    wait_idle("stall", 50);
    compare_bytes("stall_recover");

    // Randomized rounds: arbitration only among slots pending while idle.
    tx_auto = 1'b1;
    for (int r = 0; r < 30; r++) begin
      tx_delay = $urandom_range(0, 3);
      tx_len   = $urandom_range(1, 12);
      kind     = $urandom_range(0, 4);
      k        = $urandom_range(1, 3);
      d        = 8'($urandom);
      a        = 16'($urandom);
      case (kind)
        0: begin
          inject(1'b1, d, 1'b0, a);
          expect_txn(1'b0, d, a);
        end
        1: begin
          inject(1'b0, d, 1'b1, a);
          expect_txn(1'b1, d, a);
        end
        2: begin
          inject(1'b1, d, 1'b1, a);
          fa = first_is_alu();
          expect_txn(fa, d, a);
          expect_txn(!fa, d, a);
        end
        3: begin
          inject(1'b1, d, 1'b0, a);
          cyc(k - 1);
          inject(1'b0, d, 1'b1, a);
          expect_txn(1'b0, d, a);
          expect_txn(1'b1, d, a);
        end
        default: begin
          inject(1'b0, d, 1'b1, a);
          cyc(k - 1);
          inject(1'b1, d, 1'b0, a);
          expect_txn(1'b1, d, a);
          expect_txn(1'b0, d, a);
        end
      endcase
      wait_idle("rand", 400);
      compare_bytes("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
